// File: rtl/alu_operand_stack.sv
// alu_operand_stack: operand stack and sequencer feeding an 8-bit ALU in a stack-machine datapath.
//
// Accepts PUSH/POP/DUP/SWAP/ALU commands. It reads the two top entries one per
// cycle through a single read port and presents them to the ALU. It then writes
// the result back, or latches the compare flag for BE/BNE.
//
// Ports:
//   CLK, reset_n            clock, asynchronous active-low reset
//   cmd_valid/cmd_ready     command handshake (ready only while idle)
//   cmd, cmd_op, cmd_imm    command code, ALU opcode, PUSH data
//   err_clr                 sticky-error clear (only with ALU_OPERAND_STACK_ERR_CLR_EN)
//   alu_op, alu_a, alu_b    registered ALU operands, updated on entry to EXEC
//   alu_rslt, alu_z         ALU result and compare flag
//   top, depth, empty, full stack status
//   flag_z, err             latched branch flag, sticky overflow/underflow flag
//
// Optional feature macro: ALU_OPERAND_STACK_ERR_CLR_EN adds the err_clr input.
module alu_operand_stack #(
    parameter int DEPTH = 16,
    parameter int W     = 8
) (
    input  logic                     CLK,
    input  logic                     reset_n,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [2:0]               cmd,
    input  logic [2:0]               cmd_op,
    input  logic [W-1:0]             cmd_imm,
`ifdef ALU_OPERAND_STACK_ERR_CLR_EN
    input  logic                     err_clr,
`endif
    output logic [2:0]               alu_op,
    output logic [W-1:0]             alu_a,
    output logic [W-1:0]             alu_b,
    input  logic [W-1:0]             alu_rslt,
    input  logic                     alu_z,
    output logic [W-1:0]             top,
    output logic [$clog2(DEPTH):0]   depth,
    output logic                     empty,
    output logic                     full,
    output logic                     flag_z,
    output logic                     err
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [2:0] C_PUSH = 3'd1, C_POP = 3'd2, C_DUP = 3'd3, C_SWAP = 3'd4, C_ALU = 3'd5;
    localparam logic [2:0] OP_ADD = 3'd0, OP_BE = 3'd6, OP_BNE = 3'd7;

    typedef enum logic [2:0] {S_IDLE, S_RD_B, S_RD_A, S_EXEC, S_WB} state_t;

    logic [W-1:0] r_mem [DEPTH];
    logic [AW:0]  r_sp;
    state_t       r_state;
    logic [2:0]   r_op;
    logic [2:0]   r_alu_op;
    logic [W-1:0] r_b;
    logic [W-1:0] r_alu_a;
    logic [W-1:0] r_alu_b;
    logic [W-1:0] r_rslt;
    logic         r_z;
    logic         r_flag_z;
    logic         r_err;

    logic [AW-1:0] w_i0, w_i1, w_i2;
    logic w_empty, w_full, w_two, w_acc;
    logic w_push, w_pop, w_dup, w_swap, w_alu;
    logic w_push_ok, w_pop_ok, w_dup_ok, w_swap_ok, w_alu_ok;
    logic w_err_evt, w_branch, w_wb_push;

    // Slot indices: w_i0 is the free slot, w_i1 the top, w_i2 the entry below it.
    assign w_i0 = r_sp[AW-1:0];
    assign w_i1 = w_i0 - AW'(1);
    assign w_i2 = w_i0 - AW'(2);

    assign w_empty = (r_sp == '0);
    assign w_full  = (r_sp == (AW+1)'(DEPTH));
    assign w_two   = (r_sp >= (AW+1)'(2));

    assign w_acc  = cmd_valid && (r_state == S_IDLE);
    assign w_push = w_acc && (cmd == C_PUSH);
    assign w_pop  = w_acc && (cmd == C_POP);
    assign w_dup  = w_acc && (cmd == C_DUP);
    assign w_swap = w_acc && (cmd == C_SWAP);
    assign w_alu  = w_acc && (cmd == C_ALU);

    assign w_push_ok = w_push && !w_full;
    assign w_pop_ok  = w_pop && !w_empty;
    assign w_dup_ok  = w_dup && !w_empty && !w_full;
    assign w_swap_ok = w_swap && w_two;
    assign w_alu_ok  = w_alu && w_two;

    assign w_err_evt = (w_push && w_full) || (w_pop && w_empty) || (w_dup && (w_empty || w_full))
                    || (w_swap && !w_two) || (w_alu && !w_two);

    assign w_branch  = (r_op == OP_BE) || (r_op == OP_BNE);
    assign w_wb_push = (r_state == S_WB) && !w_branch;

    assign cmd_ready = (r_state == S_IDLE);
    assign alu_op    = r_alu_op;
    assign alu_a     = r_alu_a;
    assign alu_b     = r_alu_b;
    assign top       = w_empty ? '0 : r_mem[w_i1];
    assign depth     = r_sp;
    assign empty     = w_empty;
    assign full      = w_full;
    assign flag_z    = r_flag_z;
    assign err       = r_err;

    // Storage has no reset: entries at or above sp are never observed, so a
    // write that lands during reset cannot leak into the visible stack.
    always_ff @(posedge CLK) begin
        if (w_push_ok) r_mem[w_i0] <= cmd_imm;
        if (w_dup_ok) r_mem[w_i0] <= r_mem[w_i1];
        if (w_swap_ok) begin
            r_mem[w_i1] <= r_mem[w_i2];
            r_mem[w_i2] <= r_mem[w_i1];
        end
        if (w_wb_push) r_mem[w_i2] <= r_rslt;
    end

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            r_sp     <= '0;
            r_state  <= S_IDLE;
            r_op     <= OP_ADD;
            r_alu_op <= OP_ADD;
            r_b      <= '0;
            r_alu_a  <= '0;
            r_alu_b  <= '0;
            r_rslt   <= '0;
            r_z      <= 1'b0;
            r_flag_z <= 1'b0;
            r_err    <= 1'b0;
        end else begin
`ifdef ALU_OPERAND_STACK_ERR_CLR_EN
            r_err <= w_err_evt ? 1'b1 : (err_clr ? 1'b0 : r_err);
`else
            if (w_err_evt) r_err <= 1'b1;
`endif
            case (r_state)
                S_IDLE: begin
                    if (w_push_ok || w_dup_ok) r_sp <= r_sp + (AW+1)'(1);
                    if (w_pop_ok) r_sp <= r_sp - (AW+1)'(1);
                    if (w_alu_ok) begin
                        r_op    <= cmd_op;
                        r_state <= S_RD_B;
                    end
                end
                S_RD_B: begin
                    r_b     <= r_mem[w_i1];
                    r_state <= S_RD_A;
                end
                // Operand A goes straight to the ALU register so all three ALU
                // inputs change together on entry to EXEC.
                S_RD_A: begin
                    r_alu_op <= r_op;
                    r_alu_a  <= r_mem[w_i2];
                    r_alu_b  <= r_b;
                    r_state  <= S_EXEC;
                end
                S_EXEC: begin
                    r_rslt  <= alu_rslt;
                    r_z     <= alu_z;
                    r_state <= S_WB;
                end
                S_WB: begin
                    r_sp <= r_sp - (w_branch ? (AW+1)'(2) : (AW+1)'(1));
                    if (w_branch) r_flag_z <= r_z;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: doc/alu_operand_stack.md
Name: alu_operand_stack

Overview:
- Operand stack and sequencer that drives the 8-bit ALU. It is the producer of op/in_a/in_b and the consumer of rslt/z.
- Accepts stack commands (PUSH, POP, DUP, SWAP, ALU), pops operands and presents them to the ALU. It then writes the result back onto the stack, or latches the branch flag for BE/BNE.
- Sits between the decode stage and the alu instance in the stack-machine datapath.

Parameters:
- DEPTH, 16, number of stack entries; power of 2, minimum 4.
- W, 8, data width; must match the ALU width.

Ports:
- CLK  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  block can accept a command this cycle
- cmd  in  3  0=NOP 1=PUSH 2=POP 3=DUP 4=SWAP 5=ALU; 6 and 7 are treated as NOP
- cmd_op  in  3  ALU opcode from the definitions package; used when cmd=ALU
- cmd_imm  in  W  PUSH data
- alu_op  out  3  opcode to the ALU
- alu_a  out  W  operand A (second from top)
- alu_b  out  W  operand B (top)
- alu_rslt  in  W  ALU result
- alu_z  in  1  ALU compare flag
- top  out  W  current top-of-stack; 0 when empty
- depth  out  $clog2(DEPTH)+1  entry count
- empty  out  1  depth==0
- full  out  1  depth==DEPTH
- flag_z  out  1  latched branch flag
- err  out  1  sticky overflow/underflow flag

Behaviour:
- Reset (asynchronous, reset_n low) forces:
  - sp=0, empty=1, full=0, top=0, flag_z=0, err=0, cmd_ready=1
  - alu_op=aluADD, alu_a=0, alu_b=0, FSM=IDLE.
  - Stack memory contents are don't-care.
  - Reset mid-command aborts the command; no partial write survives.
- Handshake: a command is accepted on a rising CLK edge with cmd_valid&&cmd_ready. cmd, cmd_op and cmd_imm are captured at that edge. cmd_ready is high only in IDLE.
- FSM states: IDLE, RD_B, RD_A, EXEC, WB. The memory has one read port, so operands are read in separate cycles.
- Single-cycle commands complete at the accept edge and the FSM stays in IDLE:
  - PUSH: mem[sp]=imm; sp+1.
  - POP: sp-1.
  - DUP: mem[sp]=mem[sp-1]; sp+1.
  - SWAP: exchange the top two entries; top reflects the new order next cycle.
  - NOP: no state change.
- ALU command sequence:
  - IDLE -> RD_B, which latches b=mem[sp-1].
  - RD_B -> RD_A, which latches a=mem[sp-2].
  - RD_A -> EXEC: alu_op/alu_a/alu_b are driven and alu_rslt/alu_z are captured at the end of EXEC.
  - EXEC -> WB: the write-back happens and the FSM returns to IDLE.
  - Accept-to-next-accept is 5 cycles; cmd_ready is high again 4 cycles after the accept edge.
- Write-back rules:
  - Arithmetic/logic ops (aluADD, aluSUB, aluSL, aluSR, aluXOR, aluAND): mem[sp-2]=rslt; sp-1. flag_z is unchanged.
  - aluBE/aluBNE: sp-2, flag_z=alu_z, nothing is pushed.
  - Any other opcode: the result (all ones from the ALU default) is pushed as for arithmetic.
- alu_op/alu_a/alu_b hold their last values outside EXEC.
- Width: all data is W bits, and ALU results wrap modulo 2^W.
- Underflow: any command with insufficient entries leaves the stack unchanged, sets err=1, and the FSM stays in or returns to IDLE with no ALU cycle. Minimum entries:
  - POP, DUP: 1
  - SWAP, ALU: 2
- Overflow: PUSH or DUP with full=1 is ignored and sets err=1.
- Simultaneous events: none is possible, since one command is accepted per cycle and cmd_ready is low during an ALU sequence.
- top: combinational mem[sp-1] when not empty, otherwise 0. It is valid the cycle after a command completes.
- err is sticky until reset.

Optional Feature:
- Macro: ALU_OPERAND_STACK_ERR_CLR_EN.
- Defined: adds input err_clr (1 bit). When err_clr=1 at a CLK edge, err is cleared. If an error event occurs in the same cycle, the error wins and err=1.
- Undefined: there is no port, and err clears only on reset.

Test Plan:
- Reset check: release reset_n -> empty=1, depth=0, top=0, err=0, flag_z=0, cmd_ready=1.
- Add: PUSH 8'h05, PUSH 8'h03, ALU aluADD -> cmd_ready low for 4 cycles, alu_a=05 and alu_b=03 in EXEC; afterwards top=08, depth=1.
- Subtract wrap: PUSH 8'h02, PUSH 8'h05, ALU aluSUB -> top=8'hFD.
- Branch flag: PUSH 7, PUSH 7, ALU aluBE -> flag_z=1, depth=0. Then PUSH 7, PUSH 6, ALU aluBE -> flag_z=0.
- Full/overflow: DEPTH pushes -> full=1. PUSH 8'hAA -> depth stays DEPTH, top unchanged, err=1.
- Underflow and SWAP: reset, PUSH 1, ALU aluADD -> err=1, depth=1, top=1, no EXEC. Then PUSH 2, SWAP -> top=1. Then POP -> top=2.
